// File: rtl/fc2_mac_engine.sv
// fc2_mac_engine: sequential MAC engine for the fc2 layer, fed by a zero-latency weight ROM.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     activation beat handshake; in_data is the signed activation
//   rom_addr/rom_data     feature index out, packed NUM_NEURONS-lane weight word back (same cycle)
//   out_valid/out_ready   result handshake; out_data is the packed rescaled/saturated result
//   busy                  high from the first accepted beat until the result is taken
module fc2_mac_engine #(
  parameter int NUM_INPUTS   = 16,
  parameter int NUM_NEURONS  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int ACT_WIDTH    = 16,
  parameter int ACC_WIDTH    = 40,
  parameter int FRAC_BITS    = 8,
  parameter int OUT_WIDTH    = 16,
  parameter int APPLY_RELU   = 0,
  parameter int ADDR_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ACT_WIDTH-1:0]                in_data,
  output logic [ADDR_WIDTH-1:0]               rom_addr,
  input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] rom_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_NEURONS*OUT_WIDTH-1:0]    out_data,
  output logic                                busy
);
  localparam int PW = ACT_WIDTH + WEIGHT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] MAX_V = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;
  typedef enum logic [1:0] {ACCUM, REQUANT, OUTPUT} state_t;
  state_t                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            in_cnt_q, in_cnt_d;
  logic signed [ACC_WIDTH-1:0]      acc_q [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]      acc_d [NUM_NEURONS];
  logic signed [PW-1:0]             prod [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]      sh [NUM_NEURONS];
  logic signed [OUT_WIDTH-1:0]      sat [NUM_NEURONS];
  logic [NUM_NEURONS*OUT_WIDTH-1:0] out_data_q, out_data_d, rq;
  logic                             out_valid_q, out_valid_d;
  logic                             accept, last;
  assign in_ready  = state_q == ACCUM;
  assign accept    = in_valid && in_ready;
  assign last      = in_cnt_q == ADDR_WIDTH'(NUM_INPUTS - 1);
  assign rom_addr  = in_cnt_q;
  assign busy      = state_q != ACCUM || in_cnt_q != '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  // Per-lane multiply-accumulate and requantisation (floor shift, saturate, optional ReLU).
  always_comb begin
    rq = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      prod[i]  = PW'($signed(in_data)) * PW'($signed(rom_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      acc_d[i] = state_q == REQUANT ? '0 : accept ? acc_q[i] + ACC_WIDTH'(prod[i]) : acc_q[i];
      sh[i]    = acc_q[i] >>> FRAC_BITS;
      sat[i]   = sh[i] > MAX_V ? MAX_V[OUT_WIDTH-1:0] :
                 sh[i] < MIN_V ? MIN_V[OUT_WIDTH-1:0] : sh[i][OUT_WIDTH-1:0];
      rq[i*OUT_WIDTH +: OUT_WIDTH] = APPLY_RELU != 0 && sat[i][OUT_WIDTH-1] ? '0 : sat[i];
    end
  end
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      in_cnt_d = last ? '0 : in_cnt_q + ADDR_WIDTH'(1);
      state_d  = last ? REQUANT : ACCUM;
    end
    if (state_q == REQUANT) begin
      out_data_d  = rq;
      out_valid_d = 1'b1;
      state_d     = OUTPUT;
    end
    if (state_q == OUTPUT && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      in_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < NUM_NEURONS; i++) acc_q[i] <= acc_d[i];
    end
  end
endmodule

// File: tb/tb_fc2_mac_engine.sv
// tb_fc2_mac_engine: directed checks of fc2_mac_engine (plain and ReLU instances) against hand-computed results.
module tb_fc2_mac_engine;
  localparam int NI = 16;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_ready, out_valid, busy, in_ready_r, out_valid_r, busy_r;
  logic [3:0]   rom_addr, rom_addr_r;
  logic [255:0] rom_data, out_data, out_data_r;
  logic [255:0] rom [NI];
  logic [15:0]  acts [NI];
  logic [255:0] held;
  int checks = 0, failures = 0;
  localparam logic [255:0] E1 = {16{16'h1000}};
  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];
  fc2_mac_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );
  fc2_mac_engine #(.APPLY_RELU(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .rom_addr(rom_addr_r), .rom_data(rom_data), .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .busy(busy_r)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [15:0] w, input logic [15:0] a);
    for (int j = 0; j < NI; j++) begin
      rom[j]  = {16{w}};
      acts[j] = a;
    end
  endtask
  task automatic send(input int gap, input int from, input int to);
    for (int j = from; j < to; j++) begin
      in_valid = 1'b1;
      in_data  = acts[j];
      check("beat_addr", 256'(rom_addr), 256'(j));
      tick;
      if (gap != 0) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        check("gap_addr", 256'(rom_addr), 256'((j + 1) % NI));
        tick;
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic result(input string tag, input logic [255:0] exp, input logic [255:0] exp_r);
    for (int k = 0; k < 20 && !out_valid; k++) tick;
    check({tag, "_valid"}, 256'({out_valid, out_valid_r}), 256'(2'b11));
    check({tag, "_data"}, out_data, exp);
    check({tag, "_relu"}, out_data_r, exp_r);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_hs"}, 256'({out_valid, in_ready, busy}), 256'(3'b010));
    check({tag, "_keep"}, out_data, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    fill(16'h0100, 16'h0100);
    tick;
    tick;
    check("reset_ctl", 256'({out_valid, busy, in_ready, rom_addr}), 256'(7'b0010000));
    check("reset_data", out_data, '0);
    rst_n = 1'b1;
    tick;
    send(0, 0, 1);
    check("busy_first", 256'({busy, in_ready, rom_addr}), 256'(6'b110001));
    send(0, 1, NI);
    check("requant_ctl", 256'({out_valid, busy, in_ready, rom_addr}), 256'(7'b0100000));
    tick;
    check("latency", 256'(out_valid), 256'(1));
    result("ones", E1, E1);
    for (int j = 0; j < NI; j++) begin
      rom[j]  = 256'(16'h0100) << 48;
      acts[j] = 16'(j << 8);
    end
    send(0, 0, NI);
    result("lane3", 256'(16'h7800) << 48, 256'(16'h7800) << 48);
    fill(16'h7FFF, 16'h7FFF);
    send(0, 0, NI);
    result("sat_pos", {16{16'h7FFF}}, {16{16'h7FFF}});
    fill(16'h7FFF, 16'h8001);
    send(0, 0, NI);
    result("sat_neg", {16{16'h8000}}, '0);
    for (int j = 0; j < NI; j++) begin
      rom[j]  = 256'(16'hFFFF);
      acts[j] = 16'h0001;
    end
    send(0, 0, NI);
    result("floor", 256'(16'hFFFF), '0);
    fill(16'h0100, 16'h0100);
    send(0, 0, NI);
    for (int k = 0; k < 20 && !out_valid; k++) tick;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    for (int k = 0; k < 10; k++) begin
      check("bp_data", out_data, E1);
      check("bp_ctl", 256'({out_valid, in_ready, busy, rom_addr}), 256'(7'b1010000));
      tick;
    end
    in_valid = 1'b0;
    result("bp", E1, E1);
    send(0, 0, NI);
    result("after_bp", E1, E1);
    send(1, 0, NI);
    result("gapped", E1, E1);
    send(0, 0, 8);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", 256'({out_valid, busy, rom_addr}), '0);
    tick;
    rst_n = 1'b1;
    tick;
    send(0, 0, NI);
    result("post_rst", E1, E1);
    send(0, 0, NI);
    for (int k = 0; k < 20 && !out_valid; k++) tick;
    held = out_data;
    check("pre_rst_out", held, E1);
    rst_n = 1'b0;
    #1;
    check("rst_out_ctl", 256'({out_valid, busy, in_ready}), 256'(3'b001));
    check("rst_out_data", out_data, '0);
    tick;
    rst_n = 1'b1;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
